// File: rtl/sqrt_pkg.sv
// Shared types and constants for the square-root dispatch front end.
package sqrt_pkg;

  localparam int DATA_W      = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock in-order FIFO with occupancy count; pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes stale entries.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/sqrt_dispatch.sv
// Buffers operands, issues them one at a time to the root unit, and returns
// each root with its operand; a watchdog turns a silent root unit into an error result.
module sqrt_dispatch
  import sqrt_pkg::*;
#(
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int LW      = $clog2(DEPTH) + 1,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              sqrt_start,
  output logic [DATA_W-1:0] sqrt_x,
  input  logic              sqrt_done,
  input  logic [DATA_W-1:0] sqrt_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [LW-1:0]     level
);

  state_t            state;
  state_t            next_state;
  logic [CW-1:0]     wait_cnt;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              issue;
  logic              load;
  logic              load_err;

  // Held low while in reset so upstream cannot push into a FIFO being cleared.
  assign in_ready = reset && !full;
  assign push     = in_valid && in_ready;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (issue),
    .wdata (in_data),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Issuing only into a free output slot guarantees a done pulse always has a home.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    load       = 1'b0;
    load_err   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && (!out_valid || out_ready)) begin
          issue      = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (sqrt_done) begin
          load       = 1'b1;
          next_state = IDLE;
        end else if (wait_cnt == CW'(TIMEOUT)) begin
          load       = 1'b1;
          load_err   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sqrt_start <= 1'b0;
      sqrt_x     <= '0;
      wait_cnt   <= '0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_data   <= '0;
      out_err    <= 1'b0;
    end else begin
      state      <= next_state;
      sqrt_start <= issue;
      if (issue) begin
        sqrt_x   <= head;
        wait_cnt <= '0;
      end else if (state == WAIT && !load) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      // A fresh result takes priority over clearing the accepted one.
      if (load) begin
        out_valid <= 1'b1;
        out_x     <= sqrt_x;
        out_data  <= load_err ? '0 : sqrt_y;
        out_err   <= load_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_dispatch.sv
// Self-checking bench for sqrt_dispatch with a behavioural root-unit stub and
// an in-order scoreboard built from plain integer square roots.
module tb_sqrt_dispatch;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       sqrt_start;
  logic [7:0] sqrt_x;
  logic       sqrt_done;
  logic [7:0] sqrt_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_x;
  logic [7:0] out_data;
  logic       out_err;
  logic [2:0] level;

  sqrt_dispatch dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sqrt_start (sqrt_start),
    .sqrt_x     (sqrt_x),
    .sqrt_done  (sqrt_done),
    .sqrt_y     (sqrt_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_data   (out_data),
    .out_err    (out_err),
    .level      (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
  } vec_t;

  typedef struct {
    logic [7:0] x;
    bit         err;
  } sb_t;

  int  tests = 0;
  int  failed = 0;
  int  start_count = 0;
  int  done_count = 0;
  bit  prev_start = 1'b0;
  bit  stub_en = 1'b1;
  bit  stub_rand = 1'b0;
  int  stub_delay = 5;
  int  stub_cnt = 0;
  logic [7:0] stub_x = 8'd0;
  sb_t exp_q[$];

  function automatic int isqrt(input int x);
    int r = 0;
    for (int k = 0; k <= 16; k++) if (k * k <= x) r = k;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Root-unit stub: answers with the true root a fixed or random delay after start.
  always @(negedge clock) begin
    sqrt_done = 1'b0;
    sqrt_y    = 8'($urandom);
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0 && stub_en) begin
        sqrt_done = 1'b1;
        sqrt_y    = 8'(isqrt(int'(stub_x)));
        done_count++;
      end
    end
    if (sqrt_start) begin
      stub_cnt = stub_rand ? int'($urandom_range(1, 8)) : stub_delay;
      stub_x   = sqrt_x;
    end
  end

  // Scoreboard: every accepted operand must come back once, in order.
  always @(negedge clock) begin
    sb_t e;
    if (!reset) begin
      exp_q.delete();
      prev_start = 1'b0;
    end else begin
      if (sqrt_start) begin
        start_count++;
        check_output("start_width", 32'(prev_start), 0);
      end
      prev_start = sqrt_start;
      if (in_valid && in_ready) exp_q.push_back('{x: in_data, err: !stub_en});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("[TB] FAIL sb_unexpected: got result x=%0d, expected none", out_x);
        end else begin
          e = exp_q.pop_front();
          check_output("sb_x", out_x, e.x);
          check_output("sb_data", out_data, e.err ? 0 : isqrt(int'(e.x)));
          check_output("sb_err", out_err, e.err);
        end
      end
    end
  end

  task automatic wait_out(input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max && !ok; n++) begin
      @(negedge clock);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) begin
      tests++;
      failed++;
      $display("[TB] FAIL wait_out: got no out_valid, expected one within %0d cycles", max);
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid || level != 0) && n < max) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= max) begin
      tests++;
      failed++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] x, input logic [7:0] exp_y, input bit exp_err);
    int s0 = start_count;
    bit ok;
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    check_output("start_after_push", 32'(sqrt_start), 1);
    check_output("issue_x", sqrt_x, x);
    wait_out(40, ok);
    if (ok) begin
      check_output("out_x", out_x, x);
      check_output("out_data", out_data, exp_y);
      check_output("out_err", out_err, exp_err);
    end
    repeat (2) @(posedge clock);
    #1;
    check_output("start_pulses", start_count - s0, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 500000");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    vec_t   vecs[8];
    logic [7:0] burst[8];
    int     idx;
    int     s0;
    bit     go;
    bit     ok;

    vecs[0] = '{x: 8'd200, y: 8'd14};
    vecs[1] = '{x: 8'd0,   y: 8'd0};
    vecs[2] = '{x: 8'd255, y: 8'd15};
    vecs[3] = '{x: 8'd144, y: 8'd12};
    vecs[4] = '{x: 8'd1,   y: 8'd1};
    vecs[5] = '{x: 8'd3,   y: 8'd1};
    vecs[6] = '{x: 8'd224, y: 8'd14};
    vecs[7] = '{x: 8'd225, y: 8'd15};
    burst   = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};

    // Reset values with random inputs.
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = 1'($urandom);
      #2;
      check_output("rst_in_ready", 32'(in_ready), 0);
      check_output("rst_level", level, 0);
      check_output("rst_start", 32'(sqrt_start), 0);
      check_output("rst_sqrt_x", sqrt_x, 0);
      check_output("rst_out_valid", 32'(out_valid), 0);
      check_output("rst_out_x", out_x, 0);
      check_output("rst_out_data", out_data, 0);
      check_output("rst_out_err", 32'(out_err), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check_output("rel_in_ready", 32'(in_ready), 1);
    check_output("rel_level", level, 0);
    @(posedge clock); #1;

    // Table of single operations.
    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i].x, vecs[i].y, 1'b0);

    // Burst against back-pressure.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 8) begin
        in_valid = 1'b1;
        in_data  = burst[idx];
      end else begin
        in_valid = 1'b0;
      end
      go = in_valid && in_ready;
      @(posedge clock); #1;
      if (go) idx++;
    end
    in_valid = 1'b0;
    check_output("burst_accepted", idx, 5);
    check_output("burst_in_ready", 32'(in_ready), 0);
    check_output("burst_level", level, 4);
    check_output("burst_out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    drain(300);
    for (int c = 0; c < 40 && idx < 8; c++) begin
      in_valid = 1'b1;
      in_data  = burst[idx];
      go = in_ready;
      @(posedge clock); #1;
      if (go) idx++;
    end
    in_valid = 1'b0;
    drain(300);
    check_output("burst_rest_level", level, 0);

    // Watchdog timeout.
    stub_en   = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd50;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clock);
    #1;
    check_output("to_not_early", 32'(out_valid), 0);
    check_output("to_x_stable", sqrt_x, 50);
    @(posedge clock); #1;
    check_output("to_out_valid", 32'(out_valid), 1);
    check_output("to_out_err", 32'(out_err), 1);
    check_output("to_out_data", out_data, 0);
    check_output("to_out_x", out_x, 50);
    out_ready = 1'b1;
    drain(50);
    stub_en = 1'b1;
    apply_stimulus(8'd100, 8'd10, 1'b0);

    // Done on the very cycle the watchdog expires.
    stub_delay = 15;
    apply_stimulus(8'd81, 8'd9, 1'b0);
    stub_delay = 5;

    // Reset while an operation is in flight with three operands queued.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(9 + 20 * i);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check_output("mid_level_before", level, 3);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    s0 = start_count;
    #1;
    check_output("mid_level", level, 0);
    check_output("mid_out_valid", 32'(out_valid), 0);
    check_output("mid_in_ready", 32'(in_ready), 1);
    repeat (10) @(posedge clock);
    #1;
    check_output("mid_late_done_ignored", 32'(out_valid), 0);
    check_output("mid_no_issue", start_count - s0, 0);
    apply_stimulus(8'd16, 8'd4, 1'b0);

    // Randomized traffic against the scoreboard.
    stub_rand = 1'b1;
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = 1'($urandom);
      @(posedge clock); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(300);
    check_output("rand_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
